jtdsp16_sio_deser: RTL and testbench
====================================

Name: jtdsp16_sio_deser

Overview:
- Downstream consumer of the DSP16 serial output port (sdo/ock/old).
- Samples the serial stream in the system clock domain and deserialises it into 16-bit words.
- Words are assigned alternately to left and right channels, and a stereo sample pair is presented to the mixer/audio output with a one-cycle valid strobe.
- Detects framing errors (a load pulse arriving mid-word) and resynchronises.

Parameters:
- MSB_FIRST, 0, 1 = first serial bit is bit 15; 0 = first bit is bit 0 (DSP16 default LSB-first)
- W, 16, word width; supported values 8 or 16

Ports:
- clk  in  1  system clock
- rst_n  in  1  asynchronous, active-low reset
- cen  in  1  clock enable at the DSP cen2 rate; all sampling is qualified by it
- en  in  1  deserialiser enable; low = ignore line, hold outputs
- sdo  in  1  serial data from DSP
- ock  in  1  serial output clock from DSP (level, cen-synchronous)
- old  in  1  output load; high at the first bit of a word
- left  out  W  last complete left word, signed
- right  out  W  last complete right word, signed
- sample  out  1  one-clk pulse: new left/right pair valid
- ch  out  1  channel of the word being received (0 = left)
- ferr  out  1  one-clk pulse on framing error
- busy  out  1  high while a word is partially received

Behaviour:
- Reset (rst_n low, asynchronous): left=0, right=0, sample=0, ch=0, ferr=0, busy=0, bit counter=0, shift register=0, ock_l=0.
- Edge detect: ock_l <= ock on cen. Bit event bev = cen & en & ock & ~ock_l. Nothing advances without cen.
- States:
  - IDLE: on bev with old=1, capture sdo as first bit, cnt=1, go to SHIFT. On bev with old=0, discard the bit (no error).
  - SHIFT, bev with old=0: capture bit, cnt++.
  - SHIFT, bev with old=1 and cnt<W: ferr pulse; discard the partial word; capture this bit as the first bit of a new word; cnt=1; ch unchanged.
  - Completion: the bev that makes cnt==W ends the word. Go to IDLE in the same cycle the word is committed.
- Bit placement:
  - LSB-first: shift right, sdo enters bit W-1; after W bits, bit 0 holds the first bit.
  - MSB-first: shift left, sdo enters bit 0.
- Commit (clk edge after the completing bev, i.e. 1-cycle latency from the completing bev):
  - ch=0: left <= word; ch <= 1.
  - ch=1: right <= word; ch <= 0; sample=1 for exactly one clk.
- busy = (state==SHIFT).
- en low:
  - Mid-word: abort the word without error; return to IDLE; cnt=0; ch unchanged.
  - Outputs hold.
  - ock_l keeps tracking, so no spurious edge occurs when en returns high.
- Simultaneous events:
  - Completing bev with old=1 is treated as a normal completion; old on the completing bit is not an error.
  - The next word needs a fresh old.
- left/right hold between commits; no wrap or saturation (pure capture).
- Reset asserted mid-word: all state cleared immediately; the first word after reset is left.

Test Plan:
- LSB-first, cen every other clk: send 0x1234 then 0xABCD, each with old on bit 0 -> left=0x1234, right=0xABCD, one sample pulse 1 clk after the 32nd bev, ferr never high.
- MSB_FIRST=1: send 0x8001 / 0x7FFE -> left=0x8001, right=0x7FFE.
- Framing: old asserted at bit 5 of a left word, then a full 0x00FF word -> one ferr pulse; left=0x00FF; ch=1; no sample.
- Bits with old=0 while IDLE, then 0x5555/0xAAAA -> leading bits ignored; pair 0x5555/0xAAAA captured.
- en dropped at bit 8 of a right word, raised again, then 0x1111 sent -> partial word discarded; 0x1111 lands in right; sample pulses; left unchanged.
- rst_n pulsed low mid-word (no clk edge needed) -> all outputs 0 instantly; the next full word goes to left.

Source files
------------

// File: rtl/jtdsp16_sio_deser_if.sv
// Serial-line and word-output bundle between the DSP16 serial port and its deserialiser.
// The master drives the line; the slave (deserialiser) returns captured words and status.
interface jtdsp16_sio_deser_if #(
    parameter int W = 16
);
    logic                cen;
    logic                en;
    logic                sdo;
    logic                ock;
    logic                old;
    logic signed [W-1:0] left;
    logic signed [W-1:0] right;
    logic                sample;
    logic                ch;
    logic                ferr;
    logic                busy;

    modport master (
        output cen, en, sdo, ock, old,
        input  left, right, sample, ch, ferr, busy
    );

    modport slave (
        input  cen, en, sdo, ock, old,
        output left, right, sample, ch, ferr, busy
    );
endinterface

// File: rtl/jtdsp16_sio_deser.sv
// Deserialises the DSP16 sdo/ock/old stream into alternating left/right words; commits 1 clk after
// the completing ock edge. No backpressure: the line cannot be stalled, so words land as they complete.
module jtdsp16_sio_deser #(
    parameter int MSB_FIRST = 0,
    parameter int W         = 16
) (
    input  logic                   clk,
    input  logic                   rst_n,
    jtdsp16_sio_deser_if.slave     bus
);
    typedef enum logic {S_IDLE, S_SHIFT} state_t;

    localparam int             CW   = $clog2(W + 1);
    localparam logic [CW-1:0]  LAST = CW'(W - 1);

    state_t              r_state, w_state_n;
    logic [CW-1:0]       r_cnt, w_cnt_n;
    logic [W-1:0]        r_sr, w_sr_n, w_shift, w_first;
    logic                r_ock_l;
    logic                w_bev, w_commit, w_ferr;
    logic signed [W-1:0] r_left, r_right;
    logic                r_sample, r_ch, r_ferr;

    assign w_bev = bus.cen & bus.en & bus.ock & ~r_ock_l;

    generate
        if (MSB_FIRST != 0) begin : g_msb
            assign w_shift = {r_sr[W-2:0], bus.sdo};
            assign w_first = {{(W-1){1'b0}}, bus.sdo};
        end else begin : g_lsb
            assign w_shift = {bus.sdo, r_sr[W-1:1]};
            assign w_first = {bus.sdo, {(W-1){1'b0}}};
        end
    endgenerate

    always_comb begin
        w_state_n = r_state;
        w_cnt_n   = r_cnt;
        w_sr_n    = r_sr;
        w_commit  = 1'b0;
        w_ferr    = 1'b0;
        if (bus.cen && !bus.en) begin
            // disabling mid-word drops the partial word silently
            w_state_n = S_IDLE;
            w_cnt_n   = '0;
        end else if (w_bev) begin
            case (r_state)
                S_IDLE: begin
                    if (bus.old) begin
                        w_sr_n    = w_first;
                        w_cnt_n   = CW'(1);
                        w_state_n = S_SHIFT;
                    end
                end
                S_SHIFT: begin
                    // old on the last bit still completes the word
                    if (r_cnt == LAST) begin
                        w_sr_n    = w_shift;
                        w_cnt_n   = '0;
                        w_commit  = 1'b1;
                        w_state_n = S_IDLE;
                    end else if (bus.old) begin
                        w_ferr  = 1'b1;
                        w_sr_n  = w_first;
                        w_cnt_n = CW'(1);
                    end else begin
                        w_sr_n  = w_shift;
                        w_cnt_n = r_cnt + 1'b1;
                    end
                end
                default: w_state_n = S_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_n;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_cnt    <= '0;
            r_sr     <= '0;
            r_ock_l  <= 1'b0;
            r_left   <= '0;
            r_right  <= '0;
            r_sample <= 1'b0;
            r_ch     <= 1'b0;
            r_ferr   <= 1'b0;
        end else begin
            r_cnt    <= w_cnt_n;
            r_sr     <= w_sr_n;
            r_sample <= 1'b0;
            r_ferr   <= w_ferr;
            if (bus.cen) r_ock_l <= bus.ock;
            if (w_commit) begin
                if (!r_ch) begin
                    r_left <= w_sr_n;
                    r_ch   <= 1'b1;
                end else begin
                    r_right  <= w_sr_n;
                    r_ch     <= 1'b0;
                    r_sample <= 1'b1;
                end
            end
        end
    end

    assign bus.left   = r_left;
    assign bus.right  = r_right;
    assign bus.sample = r_sample;
    assign bus.ch     = r_ch;
    assign bus.ferr   = r_ferr;
    assign bus.busy   = (r_state == S_SHIFT);
endmodule

// File: tb/tb_jtdsp16_sio_deser.sv
// Directed bench for jtdsp16_sio_deser: an LSB-first and an MSB-first instance share one serial line.
module tb_jtdsp16_sio_deser;
    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    logic cen   = 1'b0;
    logic en    = 1'b0;
    logic sdo   = 1'b0;
    logic ock   = 1'b0;
    logic old   = 1'b0;

    int n_chk  = 0;
    int n_fail = 0;
    int n_samp_l = 0;
    int n_samp_m = 0;
    int n_ferr_l = 0;
    int s0, s1, f0;

    jtdsp16_sio_deser_if #(.W(16)) bus_l ();
    jtdsp16_sio_deser_if #(.W(16)) bus_m ();

    assign bus_l.cen = cen;
    assign bus_l.en  = en;
    assign bus_l.sdo = sdo;
    assign bus_l.ock = ock;
    assign bus_l.old = old;
    assign bus_m.cen = cen;
    assign bus_m.en  = en;
    assign bus_m.sdo = sdo;
    assign bus_m.ock = ock;
    assign bus_m.old = old;

    jtdsp16_sio_deser #(.MSB_FIRST(0), .W(16)) dut_l (.clk(clk), .rst_n(rst_n), .bus(bus_l));
    jtdsp16_sio_deser #(.MSB_FIRST(1), .W(16)) dut_m (.clk(clk), .rst_n(rst_n), .bus(bus_m));

    always #5 clk = ~clk;

    initial begin
        forever begin
            @(posedge clk);
            #1 cen = ~cen;
        end
    end

    always @(posedge clk) begin
        if (bus_l.sample === 1'b1) n_samp_l++;
        if (bus_m.sample === 1'b1) n_samp_m++;
        if (bus_l.ferr   === 1'b1) n_ferr_l++;
    end

    task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic wait_clk(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic send_bit(input logic b, input logic o);
        sdo = b;
        old = o;
        ock = 1'b1;
        wait_clk(4);
        ock = 1'b0;
        old = 1'b0;
        wait_clk(4);
    endtask

    task automatic send_bits(input logic [15:0] w, input int n, input bit msb);
        for (int i = 0; i < n; i++)
            send_bit(msb ? w[15-i] : w[i], i == 0);
    endtask

    initial begin
        rst_n = 1'b0;
        en    = 1'b1;
        wait_clk(4);
        chk("rst_left",   bus_l.left,   16'h0000);
        chk("rst_right",  bus_l.right,  16'h0000);
        chk("rst_sample", {15'd0, bus_l.sample}, 16'h0);
        chk("rst_ch",     {15'd0, bus_l.ch},     16'h0);
        chk("rst_ferr",   {15'd0, bus_l.ferr},   16'h0);
        chk("rst_busy",   {15'd0, bus_l.busy},   16'h0);
        chk("rst_m_left", bus_m.left,   16'h0000);
        rst_n = 1'b1;
        wait_clk(2);

        // LSB-first stereo pair
        s0 = n_samp_l; f0 = n_ferr_l;
        send_bits(16'h1234, 16, 1'b0);
        chk("t1_left",     bus_l.left,  16'h1234);
        chk("t1_ch_after_left", {15'd0, bus_l.ch}, 16'h1);
        chk("t1_busy_idle", {15'd0, bus_l.busy}, 16'h0);
        chk("t1_no_sample_yet", 16'(n_samp_l - s0), 16'd0);
        send_bits(16'hABCD, 16, 1'b0);
        chk("t1_right",    bus_l.right, 16'hABCD);
        chk("t1_left_hold", bus_l.left, 16'h1234);
        chk("t1_ch_back",  {15'd0, bus_l.ch}, 16'h0);
        chk("t1_samples",  16'(n_samp_l - s0), 16'd1);
        chk("t1_no_ferr",  16'(n_ferr_l - f0), 16'd0);

        // MSB-first instance
        rst_n = 1'b0;
        wait_clk(2);
        rst_n = 1'b1;
        wait_clk(2);
        s1 = n_samp_m;
        send_bits(16'h8001, 16, 1'b1);
        send_bits(16'h7FFE, 16, 1'b1);
        chk("t2_m_left",    bus_m.left,  16'h8001);
        chk("t2_m_right",   bus_m.right, 16'h7FFE);
        chk("t2_m_samples", 16'(n_samp_m - s1), 16'd1);

        // framing error: old arrives at bit 5 of a left word
        s0 = n_samp_l; f0 = n_ferr_l;
        send_bits(16'hFFFF, 5, 1'b0);
        chk("t3_busy_partial", {15'd0, bus_l.busy}, 16'h1);
        send_bits(16'h00FF, 16, 1'b0);
        chk("t3_ferr_pulses", 16'(n_ferr_l - f0), 16'd1);
        chk("t3_left",        bus_l.left, 16'h00FF);
        chk("t3_ch",          {15'd0, bus_l.ch}, 16'h1);
        chk("t3_no_sample",   16'(n_samp_l - s0), 16'd0);

        // en dropped at bit 8 of a right word, ock rising while disabled
        s0 = n_samp_l; f0 = n_ferr_l;
        send_bits(16'hFFFF, 8, 1'b0);
        en  = 1'b0;
        wait_clk(4);
        chk("t5_busy_aborted", {15'd0, bus_l.busy}, 16'h0);
        sdo = 1'b1;
        old = 1'b1;
        ock = 1'b1;
        wait_clk(4);
        en  = 1'b1;
        wait_clk(4);
        chk("t5_no_spurious_edge", {15'd0, bus_l.busy}, 16'h0);
        ock = 1'b0;
        old = 1'b0;
        wait_clk(4);
        send_bits(16'h1111, 16, 1'b0);
        chk("t5_right",      bus_l.right, 16'h1111);
        chk("t5_left_hold",  bus_l.left,  16'h00FF);
        chk("t5_samples",    16'(n_samp_l - s0), 16'd1);
        chk("t5_no_ferr",    16'(n_ferr_l - f0), 16'd0);

        // stray bits while idle are ignored
        s0 = n_samp_l;
        send_bit(1'b1, 1'b0);
        send_bit(1'b0, 1'b0);
        send_bit(1'b1, 1'b0);
        chk("t4_idle_busy", {15'd0, bus_l.busy}, 16'h0);
        send_bits(16'h5555, 16, 1'b0);
        send_bits(16'hAAAA, 16, 1'b0);
        chk("t4_left",    bus_l.left,  16'h5555);
        chk("t4_right",   bus_l.right, 16'hAAAA);
        chk("t4_samples", 16'(n_samp_l - s0), 16'd1);

        // asynchronous reset mid-word
        send_bits(16'hFFFF, 6, 1'b0);
        chk("t6_busy_mid", {15'd0, bus_l.busy}, 16'h1);
        #2 rst_n = 1'b0;
        #1;
        chk("t6_rst_left",  bus_l.left,  16'h0000);
        chk("t6_rst_right", bus_l.right, 16'h0000);
        chk("t6_rst_ch",    {15'd0, bus_l.ch},   16'h0);
        chk("t6_rst_busy",  {15'd0, bus_l.busy}, 16'h0);
        wait_clk(2);
        rst_n = 1'b1;
        wait_clk(2);
        send_bits(16'h0F0F, 16, 1'b0);
        chk("t6_left_after", bus_l.left,  16'h0F0F);
        chk("t6_right_zero", bus_l.right, 16'h0000);
        chk("t6_ch_after",   {15'd0, bus_l.ch}, 16'h1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
